// File: rtl/pong_pkg.sv
// Shared Pong datapath constants and types.
package pong_pkg;

  localparam int SCREEN_H = 480;
  localparam int SCREEN_W = 640;
  localparam int PADDLE_H = 120;
  localparam int PADDLE_W = 10;
  localparam int Y_W      = 10;

  // Lowest legal paddle top and the centred rest position
  localparam int Y_MAX = SCREEN_H - PADDLE_H;
  localparam int Y_CTR = Y_MAX / 2;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AI     = 1'b1
  } mode_e;

endpackage

// File: rtl/paddle_ctrl_if.sv
// Player-input / paddle-output bundle between the Pong core and paddle_ctrl.
interface paddle_ctrl_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int Y_W         = 10
);
  logic [NUM_PLAYERS-1:0]     btn_up;
  logic [NUM_PLAYERS-1:0]     btn_dn;
  logic [NUM_PLAYERS-1:0]     ai_mode;
  logic [Y_W-1:0]             ball_y;
  logic                       recentre;
  logic [NUM_PLAYERS*Y_W-1:0] paddle_y;
  logic [NUM_PLAYERS-1:0]     at_top;
  logic [NUM_PLAYERS-1:0]     at_bottom;
  logic                       tick;

  modport master (
    output btn_up, btn_dn, ai_mode, ball_y, recentre,
    input  paddle_y, at_top, at_bottom, tick
  );

  modport slave (
    input  btn_up, btn_dn, ai_mode, ball_y, recentre,
    output paddle_y, at_top, at_bottom, tick
  );
endinterface

// File: rtl/paddle_channel.sv
// One paddle: button synchronisers/debouncers, manual/AI move and clamped position.
module paddle_channel #(
  parameter int Y_W          = 10,
  parameter int PADDLE_H     = 120,
  parameter int Y_MAX        = 360,
  parameter int Y_CTR        = 180,
  parameter int STEP         = 10,
  parameter int AI_STEP      = 6,
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_btn_up,
  input  logic           i_btn_dn,
  input  logic           i_ai_mode,
  input  logic [Y_W-1:0] i_ball_y,
  input  logic           i_tick,
  input  logic           i_recentre,
  output logic [Y_W-1:0] o_paddle_y,
  output logic           o_at_top,
  output logic           o_at_bottom
);
  import pong_pkg::*;

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int SW    = Y_W + 2;

  localparam logic signed [SW-1:0] HALF_S  = SW'(PADDLE_H / 2);
  localparam logic signed [SW-1:0] YMAX_S  = SW'(Y_MAX);
  localparam logic signed [SW-1:0] AISTP_S = SW'(AI_STEP);
  localparam logic [Y_W:0]         STEP_X  = (Y_W+1)'(STEP);
  localparam logic [Y_W:0]         YMAX_X  = (Y_W+1)'(Y_MAX);

  // bit 0 = up, bit 1 = down
  logic [1:0]           r_sync1;
  logic [1:0]           r_sync2;
  logic [1:0]           r_btn;
  logic [CNT_W-1:0]     r_db_cnt [2];
  logic [Y_W-1:0]       r_y;
  logic [Y_W-1:0]       w_y_next;
  logic [Y_W:0]         w_y_ext;
  logic signed [SW-1:0] w_y_s;
  logic signed [SW-1:0] w_tgt_raw;
  logic signed [SW-1:0] w_tgt;
  logic signed [SW-1:0] w_diff;
  mode_e                w_mode;

  // Synchronise raw buttons, accept a new level once it has persisted DEBOUNCE_CYC cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_btn   <= '0;
      for (int k = 0; k < 2; k++) r_db_cnt[k] <= '0;
    end else begin
      r_sync1 <= {i_btn_dn, i_btn_up};
      r_sync2 <= r_sync1;
      for (int k = 0; k < 2; k++) begin
        if (r_sync2[k] != r_btn[k]) begin
          if (r_db_cnt[k] == CNT_W'(DEBOUNCE_CYC - 1)) begin
            r_btn[k]    <= r_sync2[k];
            r_db_cnt[k] <= '0;
          end else begin
            r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
          end
        end else begin
          r_db_cnt[k] <= '0;
        end
      end
    end
  end

  // Next position for a tick: manual steps or AI tracking, always clamped to [0, Y_MAX]
  always_comb begin
    w_mode    = i_ai_mode ? MODE_AI : MODE_MANUAL;
    w_y_ext   = {1'b0, r_y};
    w_y_s     = $signed({2'b00, r_y});
    w_tgt_raw = $signed({2'b00, i_ball_y}) - HALF_S;
    if (w_tgt_raw[SW-1])         w_tgt = '0;
    else if (w_tgt_raw > YMAX_S) w_tgt = YMAX_S;
    else                         w_tgt = w_tgt_raw;
    w_diff   = w_tgt - w_y_s;
    w_y_next = r_y;
    case (w_mode)
      MODE_AI: begin
        if ((w_diff <= AISTP_S) && (w_diff >= -AISTP_S)) w_y_next = w_tgt[Y_W-1:0];
        else if (w_diff > 0)                             w_y_next = r_y + Y_W'(AI_STEP);
        else                                             w_y_next = r_y - Y_W'(AI_STEP);
      end
      default: begin
        if (r_btn[0] && !r_btn[1])
          w_y_next = (w_y_ext >= STEP_X) ? r_y - Y_W'(STEP) : '0;
        else if (r_btn[1] && !r_btn[0])
          w_y_next = (w_y_ext + STEP_X <= YMAX_X) ? r_y + Y_W'(STEP) : Y_W'(Y_MAX);
      end
    endcase
  end

  // Position register: recentre beats a coincident tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_y <= Y_W'(Y_CTR);
    else if (i_recentre) r_y <= Y_W'(Y_CTR);
    else if (i_tick)     r_y <= w_y_next;
  end

  assign o_paddle_y  = r_y;
  assign o_at_top    = (r_y == '0);
  assign o_at_bottom = (r_y == Y_W'(Y_MAX));

endmodule

// File: rtl/paddle_ctrl.sv
// Multi-player paddle controller: shared movement tick plus one paddle_channel per player.
module paddle_ctrl #(
  parameter int NUM_PLAYERS  = 2,
  parameter int Y_W          = pong_pkg::Y_W,
  parameter int SCREEN_H     = pong_pkg::SCREEN_H,
  parameter int PADDLE_H     = pong_pkg::PADDLE_H,
  parameter int STEP         = 10,
  parameter int AI_STEP      = 6,
  parameter int TICK_DIV     = 833333,
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic          clk,
  input  logic          reset,
  paddle_ctrl_if.slave  bus
);
  import pong_pkg::*;

  localparam int LIM_Y  = SCREEN_H - PADDLE_H;
  localparam int MID_Y  = LIM_Y / 2;
  localparam int TCNT_W = $clog2(TICK_DIV);

  if (PADDLE_H >= SCREEN_H) begin : g_bad_paddle
    $error("paddle_ctrl: PADDLE_H must be smaller than SCREEN_H");
  end
  if (STEP > LIM_Y || AI_STEP > LIM_Y) begin : g_bad_step
    $error("paddle_ctrl: STEP and AI_STEP must not exceed the paddle travel");
  end
  if (TICK_DIV < 2) begin : g_bad_tick
    $error("paddle_ctrl: TICK_DIV must be at least 2");
  end
  if (DEBOUNCE_CYC < 1) begin : g_bad_db
    $error("paddle_ctrl: DEBOUNCE_CYC must be at least 1");
  end

  logic [TCNT_W-1:0] r_tick_cnt;
  logic              w_tick;
  logic [Y_W-1:0]    w_y   [NUM_PLAYERS];
  logic              w_top [NUM_PLAYERS];
  logic              w_bot [NUM_PLAYERS];

  assign w_tick = (r_tick_cnt == TCNT_W'(TICK_DIV - 1));

  // Free-running frame divider; recentre deliberately leaves it alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_ch
    paddle_channel #(
      .Y_W          (Y_W),
      .PADDLE_H     (PADDLE_H),
      .Y_MAX        (LIM_Y),
      .Y_CTR        (MID_Y),
      .STEP         (STEP),
      .AI_STEP      (AI_STEP),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .i_btn_up    (bus.btn_up[i]),
      .i_btn_dn    (bus.btn_dn[i]),
      .i_ai_mode   (bus.ai_mode[i]),
      .i_ball_y    (bus.ball_y),
      .i_tick      (w_tick),
      .i_recentre  (bus.recentre),
      .o_paddle_y  (w_y[i]),
      .o_at_top    (w_top[i]),
      .o_at_bottom (w_bot[i])
    );
  end

  // Pack per-channel results onto the bus
  always_comb begin
    bus.paddle_y  = '0;
    bus.at_top    = '0;
    bus.at_bottom = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      bus.paddle_y[i*Y_W +: Y_W] = w_y[i];
      bus.at_top[i]              = w_top[i];
      bus.at_bottom[i]           = w_bot[i];
    end
  end

  assign bus.tick = w_tick;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: stimulus table, corner-case sequences, random run vs reference model.
module tb_paddle_ctrl;

  localparam int NP = 2;
  localparam int YW = 10;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int YMAX = 360;
  localparam int YCTR = 180;
  localparam int STP = 10;
  localparam int AISTP = 6;
  localparam int HALFH = 60;

  logic clk = 1'b0;
  logic reset = 1'b0;

  paddle_ctrl_if #(.NUM_PLAYERS(NP), .Y_W(YW)) bus ();

  paddle_ctrl #(
    .NUM_PLAYERS(NP), .Y_W(YW), .SCREEN_H(480), .PADDLE_H(120),
    .STEP(STP), .AI_STEP(AISTP), .TICK_DIV(TD), .DEBOUNCE_CYC(DB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  int m_y   [NP];
  int m_s1  [NP][2];
  int m_s2  [NP][2];
  int m_acc [NP][2];
  int m_run [NP][2];
  int m_cyc;

  typedef struct {
    logic [1:0] up;
    logic [1:0] dn;
    logic [1:0] ai;
    logic [9:0] ball;
    logic       rc;
    int         cyc;
    logic [9:0] e0;
    logic [9:0] e1;
    logic [1:0] etop;
    logic [1:0] ebot;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_y[p] = YCTR;
      for (int b = 0; b < 2; b++) begin
        m_s1[p][b] = 0; m_s2[p][b] = 0; m_acc[p][b] = 0; m_run[p][b] = 0;
      end
    end
    m_cyc = 0;
  endtask

  // one clock edge of the behavioural model, using inputs as presented before the edge
  task automatic model_edge();
    int  ny [NP];
    int  tgt, raw;
    bit  tk;
    tk = ((m_cyc % TD) == TD - 1);
    for (int p = 0; p < NP; p++) begin
      ny[p] = m_y[p];
      if (bus.recentre) ny[p] = YCTR;
      else if (tk) begin
        if (bus.ai_mode[p]) begin
          tgt = int'(bus.ball_y) - HALFH;
          if (tgt < 0) tgt = 0;
          if (tgt > YMAX) tgt = YMAX;
          if (tgt - m_y[p] <= AISTP && m_y[p] - tgt <= AISTP) ny[p] = tgt;
          else if (tgt > m_y[p]) ny[p] = m_y[p] + AISTP;
          else ny[p] = m_y[p] - AISTP;
        end else if (m_acc[p][0] == 1 && m_acc[p][1] == 0) begin
          ny[p] = (m_y[p] - STP < 0) ? 0 : m_y[p] - STP;
        end else if (m_acc[p][1] == 1 && m_acc[p][0] == 0) begin
          ny[p] = (m_y[p] + STP > YMAX) ? YMAX : m_y[p] + STP;
        end
      end
      for (int b = 0; b < 2; b++) begin
        raw = (b == 0) ? int'(bus.btn_up[p]) : int'(bus.btn_dn[p]);
        if (m_s2[p][b] != m_acc[p][b]) begin
          m_run[p][b]++;
          if (m_run[p][b] >= DB) begin
            m_acc[p][b] = m_s2[p][b];
            m_run[p][b] = 0;
          end
        end else m_run[p][b] = 0;
        m_s2[p][b] = m_s1[p][b];
        m_s1[p][b] = raw;
      end
    end
    for (int p = 0; p < NP; p++) m_y[p] = ny[p];
    m_cyc++;
  endtask

  function automatic logic [63:0] model_out();
    logic [63:0] r;
    r = '0;
    r[24:15] = 10'(m_y[1]);
    r[14:5]  = 10'(m_y[0]);
    r[4]     = (m_y[1] == 0);
    r[3]     = (m_y[0] == 0);
    r[2]     = (m_y[1] == YMAX);
    r[1]     = (m_y[0] == YMAX);
    r[0]     = ((m_cyc % TD) == TD - 1);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    else model_reset();
    #1;
    check("cycle", 64'({bus.paddle_y, bus.at_top, bus.at_bottom, bus.tick}), model_out());
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (!bus.tick && n < 2 * TD) begin
      step();
      n++;
    end
    check("tick_wait", 64'(bus.tick), 64'd1);
  endtask

  initial begin
    bus.btn_up = '0; bus.btn_dn = '0; bus.ai_mode = '0; bus.ball_y = '0; bus.recentre = 1'b0;
    model_reset();

    tbl[0] = '{up:2'b00, dn:2'b00, ai:2'b00, ball:10'd0,   rc:1'b0, cyc:8,   e0:10'd180, e1:10'd180, etop:2'b00, ebot:2'b00};
    tbl[1] = '{up:2'b00, dn:2'b01, ai:2'b00, ball:10'd0,   rc:1'b0, cyc:100, e0:10'd360, e1:10'd180, etop:2'b00, ebot:2'b01};
    tbl[2] = '{up:2'b01, dn:2'b00, ai:2'b00, ball:10'd0,   rc:1'b0, cyc:200, e0:10'd0,   e1:10'd180, etop:2'b01, ebot:2'b00};
    tbl[3] = '{up:2'b00, dn:2'b00, ai:2'b10, ball:10'd400, rc:1'b0, cyc:150, e0:10'd0,   e1:10'd340, etop:2'b01, ebot:2'b00};
    tbl[4] = '{up:2'b00, dn:2'b00, ai:2'b10, ball:10'd30,  rc:1'b0, cyc:260, e0:10'd0,   e1:10'd0,   etop:2'b11, ebot:2'b00};
    tbl[5] = '{up:2'b11, dn:2'b11, ai:2'b00, ball:10'd30,  rc:1'b0, cyc:40,  e0:10'd0,   e1:10'd0,   etop:2'b11, ebot:2'b00};
    tbl[6] = '{up:2'b00, dn:2'b00, ai:2'b00, ball:10'd30,  rc:1'b1, cyc:1,   e0:10'd180, e1:10'd180, etop:2'b00, ebot:2'b00};
    tbl[7] = '{up:2'b00, dn:2'b00, ai:2'b00, ball:10'd30,  rc:1'b0, cyc:20,  e0:10'd180, e1:10'd180, etop:2'b00, ebot:2'b00};

    // reset state
    step(); step();
    check("reset_y", 64'(bus.paddle_y), 64'({10'd180, 10'd180}));
    check("reset_flags", 64'({bus.at_top, bus.at_bottom, bus.tick}), 64'd0);
    reset = 1'b1;

    // table-driven segments
    for (int i = 0; i < 8; i++) begin
      bus.btn_up = tbl[i].up; bus.btn_dn = tbl[i].dn; bus.ai_mode = tbl[i].ai;
      bus.ball_y = tbl[i].ball; bus.recentre = tbl[i].rc;
      repeat (tbl[i].cyc) step();
      check($sformatf("vec%0d_y0", i), 64'(bus.paddle_y[9:0]), 64'(tbl[i].e0));
      check($sformatf("vec%0d_y1", i), 64'(bus.paddle_y[19:10]), 64'(tbl[i].e1));
      check($sformatf("vec%0d_top", i), 64'(bus.at_top), 64'(tbl[i].etop));
      check($sformatf("vec%0d_bot", i), 64'(bus.at_bottom), 64'(tbl[i].ebot));
    end
    bus.recentre = 1'b0;

    // bouncing up button must not move the paddle
    for (int i = 0; i < 40; i++) begin
      bus.btn_up[0] = ((i / 2) % 2 == 0);
      step();
    end
    check("bounce_hold", 64'(bus.paddle_y[9:0]), 64'd180);
    bus.btn_up[0] = 1'b1;
    repeat (20) step();
    check("bounce_then_move", 64'(bus.paddle_y[9:0] < 10'd180), 64'd1);
    bus.btn_up[0] = 1'b0;
    repeat (12) step();

    // recentre coincident with a tick while P0 is held down
    bus.recentre = 1'b1;
    step();
    bus.recentre = 1'b0;
    bus.btn_dn[0] = 1'b1;
    repeat (8) step();
    wait_tick();
    bus.recentre = 1'b1;
    step();
    bus.recentre = 1'b0;
    check("recentre_on_tick", 64'(bus.paddle_y[9:0]), 64'd180);
    wait_tick();
    step();
    check("move_after_recentre", 64'(bus.paddle_y[9:0]), 64'd190);

    // reset in the middle of a tick period
    bus.btn_dn[0] = 1'b0;
    wait_tick();
    step(); step();
    reset = 1'b0;
    #1;
    model_reset();
    check("midreset_y", 64'(bus.paddle_y), 64'({10'd180, 10'd180}));
    check("midreset_flags", 64'({bus.at_top, bus.at_bottom, bus.tick}), 64'd0);
    step(); step();
    reset = 1'b1;
    step(); step();
    check("tick_restart_quiet", 64'(bus.tick), 64'd0);
    step();
    check("tick_restart_first", 64'(bus.tick), 64'd1);

    // randomized run against the model
    for (int i = 0; i < 1200; i++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(7) == 0) bus.btn_up[p] = ~bus.btn_up[p];
        if ($urandom_range(7) == 0) bus.btn_dn[p] = ~bus.btn_dn[p];
        if ($urandom_range(63) == 0) bus.ai_mode[p] = ~bus.ai_mode[p];
      end
      if ($urandom_range(15) == 0) bus.ball_y = 10'($urandom_range(1023));
      bus.recentre = ($urandom_range(49) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
- Parametrised multi-player paddle position controller for the Pong datapath.
- Per channel: synchronises and debounces raw up/down buttons, then moves the paddle once per frame tick.
- Hard-clamps the paddle to screen bounds. Each channel can run in manual (buttons) or AI (track ball_y) mode.
- Outputs feed the renderer and collision logic directly.

Parameters:
- NUM_PLAYERS, 2, number of independent paddle channels
- Y_W, 10, width of vertical coordinates
- SCREEN_H, 480, visible lines
- PADDLE_H, 120, paddle height in lines
- STEP, 10, manual move per tick in lines
- AI_STEP, 6, AI move per tick in lines
- TICK_DIV, 833333, clk cycles per movement tick (60 Hz at 50 MHz)
- DEBOUNCE_CYC, 250000, cycles an input must be stable before it is accepted

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- btn_up  in  NUM_PLAYERS  raw asynchronous up buttons, bit i = player i (up decreases y)
- btn_dn  in  NUM_PLAYERS  raw asynchronous down buttons
- ai_mode  in  NUM_PLAYERS  1 = channel i tracks ball, buttons ignored
- ball_y  in  Y_W  current ball top y, synchronous to clk
- recentre  in  1  synchronous one-cycle pulse, recentres all paddles
- paddle_y  out  NUM_PLAYERS*Y_W  packed paddle top y, channel i at [i*Y_W +: Y_W]
- at_top  out  NUM_PLAYERS  paddle_y == 0
- at_bottom  out  NUM_PLAYERS  paddle_y == Y_MAX
- tick  out  1  movement tick pulse, one clk wide

Behaviour:
- Constants:
  - Y_MAX = SCREEN_H - PADDLE_H = 360
  - Y_CTR = Y_MAX/2 = 180
- Reset (async assert, sync release):
  - every paddle_y = Y_CTR; at_top = at_bottom = 0
  - tick = 0; tick counter = 0
  - debounced button state = 0; debounce counters = 0; synchronisers = 0
- Tick generator:
  - counter runs 0..TICK_DIV-1, wraps to 0
  - tick = 1 in the cycle the counter equals TICK_DIV-1, else 0
- Input path, per button:
  - 2-flop synchroniser, then debouncer
  - debouncer: when the synchronised value differs from the accepted value for DEBOUNCE_CYC consecutive cycles, the accepted value updates
  - any return to the accepted value restarts the count
  - latency from raw edge to accepted edge = DEBOUNCE_CYC + 2 cycles
- Manual mode, evaluated only on cycles with tick = 1; registered, paddle_y updates the following clk:
  - up only: y = (y >= STEP) ? y - STEP : 0
  - down only: y = (y + STEP <= Y_MAX) ? y + STEP : Y_MAX
  - both or neither: hold
  - arithmetic in Y_W+1 bits; no wrap-around. y never leaves [0, Y_MAX].
- AI mode, on tick:
  - target = ball_y - PADDLE_H/2, saturated to [0, Y_MAX] (signed Y_W+1 compute)
  - if |target - y| <= AI_STEP then y = target
  - else y moves AI_STEP toward target
- Mode switch: takes effect at the next tick; no reset of position.
- Priority per cycle: reset > recentre > tick movement.
  - recentre sets all paddle_y = Y_CTR on the next clk, even if tick is coincident
  - recentre does not clear debounce state or the tick counter
- at_top and at_bottom are combinational from the registered paddle_y.
- Reset asserted mid-debounce or mid-tick-period: all state returns to reset values immediately.
- Elaboration checks: PADDLE_H < SCREEN_H; STEP and AI_STEP <= Y_MAX; TICK_DIV >= 2; DEBOUNCE_CYC >= 1.

Decomposition:
- Package pong_pkg:
  - SCREEN_H, SCREEN_W=640, PADDLE_H, PADDLE_W=10, Y_W
  - derived Y_MAX and Y_CTR
  - mode enum {MODE_MANUAL, MODE_AI}
- Sub-module paddle_channel, instantiated NUM_PLAYERS times via generate:
  - contains synchronisers, two debouncers, mode mux and the clamped position register
  - tick generator and recentre fan-out stay in paddle_ctrl

Test Plan (sim: TICK_DIV=4, DEBOUNCE_CYC=3, NUM_PLAYERS=2):
- Reset release, no input: paddle_y = {180,180}; tick pulses every 4 cycles; at_top = at_bottom = 0.
- P0 btn_dn held: first move after 5 cycles plus next tick. y steps 190, 200, … 360, then holds; at_bottom[0] = 1; P1 unchanged at 180.
- P0 at y=5 (preloaded via STEP=10 path from 185?), use STEP=7 build: y=180 … 12, 5, 0, then holds; no wrap to 1023; at_top[0] = 1.
- Bounce: btn_up toggles every 2 cycles for 40 cycles -> paddle_y unchanged; then stable high -> moves.
- P1 ai_mode=1, ball_y=400: target = 340; y = 186, 192, … 336, then 340 (snap), then holds. Then ball_y=30: target saturates to 0; y converges to 0.
- Both buttons held -> no motion. recentre coincident with tick while P0 held down -> y = 180 that clk, then moves to 190 on the following tick. Reset mid-tick-period -> {180,180}, counter restarts.
